// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if: BCD time word in, multiplexed 7-segment bus out
//   num     : six BCD digits, num[3:0] = digit 0 (rightmost)
//   dp_mask : decimal-point enable per digit, active-high
//   sel     : digit selects, active-low, at most one low
//   seg     : segments, active-low, {dp,g,f,e,d,c,b,a}
interface seg_scan_display_if;
    logic [23:0] num;
    logic [5:0]  dp_mask;
    logic [5:0]  sel;
    logic [7:0]  seg;
    modport master (output num, dp_mask, input sel, seg);
    modport slave  (input num, dp_mask, output sel, seg);
endinterface

// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 6-digit 7-segment driver with frame snapshot, ghost blanking and leading-zero blanking
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seg_scan_display_if (num, dp_mask in; sel, seg out)
module seg_scan_display #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500,
    parameter bit LZB_EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seg_scan_display_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    logic [CW-1:0] div_cnt;
    logic [2:0]    dig_idx;
    logic [23:0]   num_s;
    logic [5:0]    dp_s;
    logic          wrap;
    logic          blank;
    logic [3:0]    val;
    logic [6:0]    dec;
    logic [6:0]    glyph;
    assign wrap  = int'(div_cnt) == SCAN_DIV - 1;
    assign blank = int'(div_cnt) < BLANK_CYC;
    assign val   = 4'(num_s >> {dig_idx, 2'b00});
    always_comb begin
        dec = 7'h3F;
        case (val)
            4'd0: dec = 7'h40;
            4'd1: dec = 7'h79;
            4'd2: dec = 7'h24;
            4'd3: dec = 7'h30;
            4'd4: dec = 7'h19;
            4'd5: dec = 7'h12;
            4'd6: dec = 7'h02;
            4'd7: dec = 7'h78;
            4'd8: dec = 7'h00;
            4'd9: dec = 7'h10;
            default: dec = 7'h3F;
        endcase
        // odd digits are the high half of a 2-digit group; blank them when zero
        glyph = (LZB_EN && dig_idx[0] && val == 4'd0) ? 7'h7F : dec;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            dig_idx <= '0;
            num_s   <= '0;
            dp_s    <= '0;
            bus.sel <= '1;
            bus.seg <= '1;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + CW'(1);
            if (wrap)
                dig_idx <= dig_idx == 3'd5 ? 3'd0 : dig_idx + 3'd1;
            // frame-start snapshot; slot 0 starts blank, so the swap never tears
            if (dig_idx == 3'd0 && div_cnt == '0) begin
                num_s <= bus.num;
                dp_s  <= bus.dp_mask;
            end
            bus.sel <= blank ? 6'h3F : ~(6'b1 << dig_idx);
            bus.seg <= blank ? 8'hFF : {~dp_s[dig_idx], glyph};
        end
    end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: self-checking bench, LZB off (u0) and LZB on (u1) instances against a frame-level model
module tb_seg_scan_display;
    localparam int SD = 8, BC = 2, FR = 6 * SD;
    localparam logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    typedef struct {
        logic [23:0] num;
        logic [5:0]  dp;
        int          dig;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;
    logic        clk = 0, rst_n = 0;
    logic [23:0] num = 24'h123456;
    logic [5:0]  dp = '0;
    int          total = 0, bad = 0, n = 0;
    logic [23:0] snap_num = '0;
    logic [5:0]  snap_dp = '0;
    vec_t        vt [15];
    seg_scan_display_if b0 ();
    seg_scan_display_if b1 ();
    assign b0.num = num;
    assign b0.dp_mask = dp;
    assign b1.num = num;
    assign b1.dp_mask = dp;
    seg_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZB_EN(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    seg_scan_display #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZB_EN(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    always #5 clk = ~clk;

    // n = clock edges since reset release; the frame's digits are captured on its first edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            snap_num = '0;
            snap_dp = '0;
        end else begin
            n = n + 1;
            if ((n - 1) % FR == 0) begin
                snap_num = num;
                snap_dp = dp;
            end
        end
    end

    function automatic logic [13:0] model(input bit lzb);
        int p, d;
        logic [3:0] v;
        logic [6:0] g;
        if (n == 0) return 14'h3FFF;
        p = (n - 1) % FR;
        d = p / SD;
        if (p % SD < BC) return 14'h3FFF;
        v = 4'(snap_num >> (4 * d));
        g = (lzb && d % 2 == 1 && v == 0) ? 7'h7F : (v > 9) ? 7'h3F : DEC[v];
        return {~(6'b1 << d), ~snap_dp[d], g};
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (n=%0d)", nm, act, exp, n);
        end
    endtask

    task automatic goto(input int t);
        for (int i = 0; i < 5000 && n < t; i++) begin
            @(posedge clk);
            #1;
        end
        if (n != t) begin
            total++;
            bad++;
            $display("FAIL goto: at n=%0d want %0d", n, t);
        end
    endtask

    task automatic see(input string nm, input int t, input int d, input logic [7:0] e0, input logic [7:0] e1);
        logic [5:0] s;
        s = (d < 0) ? 6'h3F : ~(6'b1 << d);
        goto(t);
        chk({nm, "_u0"}, {b0.sel, b0.seg}, {s, e0});
        chk({nm, "_u1"}, {b1.sel, b1.seg}, {s, e1});
    endtask

    always @(negedge clk) begin
        chk("model_u0", {b0.sel, b0.seg}, model(0));
        chk("model_u1", {b1.sel, b1.seg}, model(1));
    end

    initial begin
        int f;
        int lit0 [6];
        int lit1 [6];
        vt = '{
            '{24'h050309, 6'h00, 0, 8'h90, 8'h90}, '{24'h050309, 6'h00, 1, 8'hC0, 8'hFF},
            '{24'h050309, 6'h00, 2, 8'hB0, 8'hB0}, '{24'h050309, 6'h00, 3, 8'hC0, 8'hFF},
            '{24'h050309, 6'h00, 4, 8'h92, 8'h92}, '{24'h050309, 6'h00, 5, 8'hC0, 8'hFF},
            '{24'h00000A, 6'h01, 0, 8'h3F, 8'h3F}, '{24'h00000A, 6'h01, 1, 8'hC0, 8'hFF},
            '{24'h000000, 6'h02, 1, 8'h40, 8'h7F}, '{24'h987654, 6'h2A, 5, 8'h10, 8'h10},
            '{24'h987654, 6'h2A, 4, 8'h80, 8'h80}, '{24'h987654, 6'h2A, 1, 8'h12, 8'h12},
            '{24'h0F0000, 6'h00, 4, 8'hBF, 8'hBF}, '{24'h070000, 6'h00, 4, 8'hF8, 8'hF8},
            '{24'h600000, 6'h20, 5, 8'h02, 8'h02}
        };
        repeat (2) @(negedge clk);
        chk("rst_u0", {b0.sel, b0.seg}, 14'h3FFF);
        chk("rst_u1", {b1.sel, b1.seg}, 14'h3FFF);
        rst_n = 1;
        see("blank1", 1, -1, 8'hFF, 8'hFF);
        see("blank2", 2, -1, 8'hFF, 8'hFF);
        see("d0", 3, 0, 8'h82, 8'h82);
        see("d0end", SD, 0, 8'h82, 8'h82);
        see("d1", SD + BC + 1, 1, 8'h92, 8'h92);
        see("d1blank", 2 * SD, 1, 8'h92, 8'h92);
        see("d2blank", 2 * SD + 1, -1, 8'hFF, 8'hFF);
        see("d5", 5 * SD + BC + 1, 5, 8'hF9, 8'hF9);
        goto(FR + 2 * SD + 4);
        num = 24'h999999;
        see("tear_d3", FR + 3 * SD + BC + 1, 3, 8'hB0, 8'hB0);
        see("tear_d5", FR + 5 * SD + BC + 1, 5, 8'hF9, 8'hF9);
        for (int d = 0; d < 6; d++)
            see("next_frame", 2 * FR + d * SD + BC + 1, d, 8'h90, 8'h90);
        foreach (vt[i]) begin
            f = n / FR + 1;
            goto(f * FR);
            num = vt[i].num;
            dp = vt[i].dp;
            see("vec", f * FR + vt[i].dig * SD + BC + 1, vt[i].dig, vt[i].e0, vt[i].e1);
        end
        num = 24'h123456;
        dp = '0;
        f = n / FR + 1;
        goto(f * FR + 4 * SD + 4);
        #2 rst_n = 0;
        #1;
        chk("async_u0", {b0.sel, b0.seg}, 14'h3FFF);
        chk("async_u1", {b1.sel, b1.seg}, 14'h3FFF);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        see("rel_blank", 1, -1, 8'hFF, 8'hFF);
        see("rel_first", BC + 1, 0, 8'h82, 8'h82);
        foreach (lit0[d]) begin
            lit0[d] = 0;
            lit1[d] = 0;
        end
        f = n / FR + 1;
        for (int k = f * FR + 1; k <= (f + 3) * FR; k++) begin
            goto(k);
            chk("onehot_u0", 14'($onehot0(~b0.sel)), 14'd1);
            chk("onehot_u1", 14'($onehot0(~b1.sel)), 14'd1);
            for (int d = 0; d < 6; d++) begin
                lit0[d] += b0.sel[d] ? 0 : 1;
                lit1[d] += b1.sel[d] ? 0 : 1;
            end
        end
        for (int d = 0; d < 6; d++) begin
            chk("lit_u0", 14'(lit0[d]), 14'(3 * (SD - BC)));
            chk("lit_u1", 14'(lit1[d]), 14'(3 * (SD - BC)));
        end
        for (int r = 0; r < 20 * FR; r++) begin
            @(negedge clk);
            if ($urandom_range(0, 11) == 0) begin
                for (int d = 0; d < 6; d++)
                    num[4 * d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
                dp = 6'($urandom);
            end
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
